pipeline_carry_skip_adder_gen: RTL and testbench

- Parametrised successor to the fixed 64-bit, 3-stage carry-skip adder in the pipeline_adder library.
- Width, skip-block size and pipeline depth are generic.
- Adds add/subtract mode, signed-overflow flag, a valid/ready handshake with backpressure, and synchronous active-low reset.
- Used as the arithmetic core in pipelined datapaths that need one result per clock and the ability to stall.

---
 rtl/pipeline_carry_skip_adder_gen.sv | 115 +++++++++++
 tb/tb_pipeline_carry_skip_adder_gen.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_carry_skip_adder_gen.sv
// Pipelined carry-skip adder/subtractor with generic width, skip-block size and depth.
// One global advance enable stalls every stage together under output backpressure.
module pipeline_carry_skip_adder_gen #(
    parameter int WIDTH  = 64,
    parameter int BLK    = 4,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NB = WIDTH / (BLK * STAGES);

    // Stage s inputs: entry 0 is the port side, entry s+1 is the register of stage s.
    logic [WIDTH-1:0] pa [STAGES];
    logic [WIDTH-1:0] pb [STAGES];
    logic [WIDTH-1:0] ps [STAGES];
    logic             pc [STAGES];
    logic             pv [STAGES];
    logic             adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign pa[0] = a;
    assign pb[0] = sub ? ~b : b;
    assign ps[0] = '0;
    assign pc[0] = sub | cin;
    assign pv[0] = in_valid;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [WIDTH-1:0] nsum;
        logic             ncarry;

        always_comb begin
            logic c;
            logic rc;
            logic p;
            int   idx;
            nsum = ps[s];
            c    = pc[s];
            rc   = 1'b0;
            p    = 1'b0;
            idx  = 0;
            for (int k = 0; k < NB; k++) begin
                rc = c;
                p  = 1'b1;
                for (int i = 0; i < BLK; i++) begin
                    idx       = (s * NB + k) * BLK + i;
                    nsum[idx] = pa[s][idx] ^ pb[s][idx] ^ rc;
                    rc        = (pa[s][idx] & pb[s][idx]) | (rc & (pa[s][idx] ^ pb[s][idx]));
                    p         = p & (pa[s][idx] ^ pb[s][idx]);
                end
                // A fully propagating block forwards its carry-in without waiting on the ripple.
                c = p ? c : rc;
            end
            ncarry = c;
        end

        if (s < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic [WIDTH-1:0] rs;
            logic             rcar;
            logic             rv;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ra   <= '0;
                    rb   <= '0;
                    rs   <= '0;
                    rcar <= 1'b0;
                    rv   <= 1'b0;
                end else if (adv) begin
                    ra   <= pa[s];
                    rb   <= pb[s];
                    rs   <= nsum;
                    rcar <= ncarry;
                    rv   <= pv[s];
                end
            end

            assign pa[s+1] = ra;
            assign pb[s+1] = rb;
            assign ps[s+1] = rs;
            assign pc[s+1] = rcar;
            assign pv[s+1] = rv;
        end else begin : g_last
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sum       <= '0;
                    cout      <= 1'b0;
                    ovf       <= 1'b0;
                    out_valid <= 1'b0;
                end else if (adv) begin
                    sum       <= nsum;
                    cout      <= ncarry;
                    ovf       <= (pa[s][WIDTH-1] == pb[s][WIDTH-1]) &&
                                 (nsum[WIDTH-1] != pa[s][WIDTH-1]);
                    out_valid <= pv[s];
                end
            end
        end
    end
endmodule

// File: tb/tb_pipeline_carry_skip_adder_gen.sv
// Self-checking bench: default instance plus three parameter variants, checked against
// an arithmetic reference model (a + b' + c on wide integers).
module tb_pipeline_carry_skip_adder_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, out_ready, cin, sub;
    logic [63:0] a, b;

    logic        in_ready, out_valid, cout, ovf;
    logic [63:0] sum;
    logic        rdy1, vld1, co1, ov1;
    logic [31:0] sum1;
    logic        rdy2, vld2, co2, ov2;
    logic [15:0] sum2;
    logic        rdy3, vld3, co3, ov3;
    logic [63:0] sum3;

    int n_cmp = 0;
    int n_err = 0;

    typedef logic [65:0] res_t;
    res_t scb[$];

    pipeline_carry_skip_adder_gen u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipeline_carry_skip_adder_gen #(.WIDTH(32), .BLK(4), .STAGES(2)) u_p1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub), .out_valid(vld1),
        .out_ready(out_ready), .sum(sum1), .cout(co1), .ovf(ov1)
    );

    pipeline_carry_skip_adder_gen #(.WIDTH(16), .BLK(2), .STAGES(8)) u_p2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub), .out_valid(vld2),
        .out_ready(out_ready), .sum(sum2), .cout(co2), .ovf(ov2)
    );

    pipeline_carry_skip_adder_gen #(.WIDTH(64), .BLK(8), .STAGES(1)) u_p3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(vld3),
        .out_ready(out_ready), .sum(sum3), .cout(co3), .ovf(ov3)
    );

    logic [63:0] obs_sum [4];
    logic        obs_v   [4];
    logic        obs_c   [4];
    logic        obs_o   [4];
    logic        obs_r   [4];

    assign obs_sum[0] = sum;
    assign obs_sum[1] = {32'b0, sum1};
    assign obs_sum[2] = {48'b0, sum2};
    assign obs_sum[3] = sum3;
    assign obs_v[0] = out_valid;
    assign obs_v[1] = vld1;
    assign obs_v[2] = vld2;
    assign obs_v[3] = vld3;
    assign obs_c[0] = cout;
    assign obs_c[1] = co1;
    assign obs_c[2] = co2;
    assign obs_c[3] = co3;
    assign obs_o[0] = ovf;
    assign obs_o[1] = ov1;
    assign obs_o[2] = ov2;
    assign obs_o[3] = ov3;
    assign obs_r[0] = in_ready;
    assign obs_r[1] = rdy1;
    assign obs_r[2] = rdy2;
    assign obs_r[3] = rdy3;

    // Reference: {ovf, cout, sum} of a w-bit add/subtract done with plain wide arithmetic.
    function automatic res_t model(input logic [63:0] av, input logic [63:0] bv,
                                   input logic c, input logic s, input int w);
        logic [63:0] mask, am, bm, sm;
        logic [64:0] full;
        logic        co, ov;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        am   = av & mask;
        bm   = (s ? ~bv : bv) & mask;
        full = {1'b0, am} + {1'b0, bm} + {64'd0, (s ? 1'b1 : c)};
        sm   = full[63:0] & mask;
        co   = full[w];
        ov   = (am[w-1] == bm[w-1]) && (sm[w-1] != am[w-1]);
        return {ov, co, sm};
    endfunction

    task automatic randomize_inputs();
        a   = {$urandom, $urandom};
        b   = {$urandom, $urandom};
        cin = 1'($urandom_range(1));
        sub = 1'($urandom_range(1));
    endtask

    task automatic issue(input logic [63:0] av, input logic [63:0] bv, input logic c, input logic s);
        a = av;
        b = bv;
        cin = c;
        sub = s;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        randomize_inputs();
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                n_cmp++;
                if (obs_v[d] !== 1'b0 || obs_sum[d] !== 64'd0 || obs_c[d] !== 1'b0 ||
                    obs_o[d] !== 1'b0 || obs_r[d] !== 1'b1) begin
                    n_err++;
                    $display("[TB] FAIL reset dut%0d cyc%0d: got v=%b sum=%h c=%b o=%b rdy=%b, expected v=0 sum=0 c=0 o=0 rdy=1",
                             d, cyc, obs_v[d], obs_sum[d], obs_c[d], obs_o[d], obs_r[d]);
                end
            end
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [63:0] va [3];
        logic [63:0] vb [3];
        logic        vc [3];
        logic        vs [3];
        res_t        ve [3];
        va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'd0; vc[0] = 1'b1; vs[0] = 1'b0;
        ve[0] = {1'b0, 1'b1, 64'd0};
        va[1] = 64'h8000_0000_0000_0000; vb[1] = 64'd1; vc[1] = 1'b0; vs[1] = 1'b1;
        ve[1] = {1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF};
        va[2] = 64'd5; vb[2] = 64'd7; vc[2] = 1'b1; vs[2] = 1'b1;
        ve[2] = {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
        for (int v = 0; v < 3; v++) begin
            issue(va[v], vb[v], vc[v], vs[v]);
            for (int e = 1; e < 4; e++) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL directed%0d early_valid edge%0d: got %b expected 0", v, e, out_valid);
                end
                @(negedge clk);
            end
            n_cmp++;
            if (out_valid !== 1'b1 || {ovf, cout, sum} !== ve[v]) begin
                n_err++;
                $display("[TB] FAIL directed%0d result: got v=%b {ovf,cout,sum}=%h expected v=1 %h",
                         v, out_valid, {ovf, cout, sum}, ve[v]);
            end
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL directed%0d consumed: got out_valid=%b expected 0", v, out_valid);
            end
        end
    endtask

    task automatic test_stream();
        res_t exp;
        int   got = 0;
        scb.delete();
        out_ready = 1'b1;
        for (int i = 0; i <= 104; i++) begin
            if (i < 100) begin
                randomize_inputs();
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            n_cmp++;
            if (out_valid !== ((i >= 4) && (i < 104))) begin
                n_err++;
                $display("[TB] FAIL stream_valid cyc%0d: got %b expected %b", i, out_valid, ((i >= 4) && (i < 104)));
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_cmp++;
                if (scb.size() == 0) begin
                    n_err++;
                    $display("[TB] FAIL stream_extra cyc%0d: got result %h expected none", i, sum);
                end else begin
                    exp = scb.pop_front();
                    got++;
                    if ({ovf, cout, sum} !== exp) begin
                        n_err++;
                        $display("[TB] FAIL stream_data cyc%0d: got %h expected %h", i, {ovf, cout, sum}, exp);
                    end
                end
            end
            if (in_valid && in_ready) scb.push_back(model(a, b, cin, sub, 64));
            @(negedge clk);
        end
        n_cmp++;
        if (got != 100 || scb.size() != 0) begin
            n_err++;
            $display("[TB] FAIL stream_count: got %0d results (%0d left) expected 100 (0 left)", got, scb.size());
        end
    endtask

    task automatic test_back_to_back();
        res_t exp;
        res_t held = '0;
        int   sent = 0;
        int   got = 0;
        logic need_new = 1'b1;
        scb.delete();
        for (int i = 0; i < 120 && (sent < 30 || scb.size() > 0); i++) begin
            out_ready = !((i >= 10) && (i < 15));
            in_valid = (sent < 30);
            if (in_valid && need_new) begin
                randomize_inputs();
                need_new = 1'b0;
            end
            #1;
            if ((i >= 10) && (i < 15)) begin
                n_cmp++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    n_err++;
                    $display("[TB] FAIL stall_ready cyc%0d: got in_ready=%b out_valid=%b expected 0 1", i, in_ready, out_valid);
                end
                if (i == 10) begin
                    held = {ovf, cout, sum};
                end else begin
                    n_cmp++;
                    if ({ovf, cout, sum} !== held) begin
                        n_err++;
                        $display("[TB] FAIL stall_hold cyc%0d: got %h expected %h", i, {ovf, cout, sum}, held);
                    end
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_cmp++;
                if (scb.size() == 0) begin
                    n_err++;
                    $display("[TB] FAIL bp_extra cyc%0d: got result %h expected none", i, sum);
                end else begin
                    exp = scb.pop_front();
                    got++;
                    if ({ovf, cout, sum} !== exp) begin
                        n_err++;
                        $display("[TB] FAIL bp_data cyc%0d: got %h expected %h", i, {ovf, cout, sum}, exp);
                    end
                end
            end
            if (in_valid && in_ready) begin
                scb.push_back(model(a, b, cin, sub, 64));
                sent++;
                need_new = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (got != 30 || scb.size() != 0) begin
            n_err++;
            $display("[TB] FAIL bp_count: got %0d results (%0d left) expected 30 (0 left)", got, scb.size());
        end
    endtask

    task automatic test_sweep();
        logic [63:0] ha [500];
        logic [63:0] hb [500];
        logic        hc [500];
        logic        hs [500];
        int          lat [4];
        int          wid [4];
        int          j;
        res_t        exp;
        lat[0] = 4; lat[1] = 2; lat[2] = 8; lat[3] = 1;
        wid[0] = 64; wid[1] = 32; wid[2] = 16; wid[3] = 64;
        out_ready = 1'b1;
        for (int ph = 0; ph < 2; ph++) begin
            rst_n = 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                n_cmp++;
                if (obs_v[d] !== 1'b0 || obs_sum[d] !== 64'd0) begin
                    n_err++;
                    $display("[TB] FAIL flush dut%0d ph%0d: got v=%b sum=%h expected v=0 sum=0", d, ph, obs_v[d], obs_sum[d]);
                end
            end
            rst_n = 1'b1;
            for (int k = 0; k < 500; k++) begin
                randomize_inputs();
                in_valid = 1'b1;
                ha[k] = a;
                hb[k] = b;
                hc[k] = cin;
                hs[k] = sub;
                @(negedge clk);
                for (int d = 0; d < 4; d++) begin
                    j = k - lat[d] + 1;
                    n_cmp++;
                    if (j < 0) begin
                        if (obs_v[d] !== 1'b0) begin
                            n_err++;
                            $display("[TB] FAIL sweep_early dut%0d k%0d: got v=%b expected 0", d, k, obs_v[d]);
                        end
                    end else begin
                        exp = model(ha[j], hb[j], hc[j], hs[j], wid[d]);
                        if (obs_v[d] !== 1'b1 || {obs_o[d], obs_c[d], obs_sum[d]} !== exp) begin
                            n_err++;
                            $display("[TB] FAIL sweep dut%0d k%0d: got v=%b %h expected v=1 %h",
                                     d, k, obs_v[d], {obs_o[d], obs_c[d], obs_sum[d]}, exp);
                        end
                    end
                end
            end
        end
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        test_reset();
        test_directed();
        repeat (2) @(negedge clk);
        test_stream();
        repeat (2) @(negedge clk);
        test_back_to_back();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
